// File: rtl/dma_cmd_seq_pkg.sv
// rtl/dma_cmd_seq_pkg.sv - shared types, status layout and helpers for the DMA command sequencer
package dma_cmd_seq_pkg;

  localparam int CMD_LEN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ABORTED   = 2;
  localparam int STAT_ERR_LEN   = 3;
  localparam int STAT_ERR_ALIGN = 4;
  localparam int STAT_ERR_CPL   = 5;
  localparam int STAT_OUT_LSB   = 8;
  localparam int STAT_BURST_LSB = 16;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - combinational burst sizing limited by length, max burst and boundary
module dma_burst_calc
  import dma_cmd_seq_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int BOUNDARY  = 4096,
  localparam int OFF_W    = $clog2(BOUNDARY)
) (
  input  logic [OFF_W-1:0] addr_off,
  input  logic [31:0]      remaining,
  output logic [8:0]       beats
);

  logic [31:0] room;
  logic [31:0] beats_full;
  logic [22:0] unused_hi;

  // Words left before the next boundary; the offset is word aligned so the shift is exact.
  always_comb begin
    room       = (32'(BOUNDARY) - 32'(addr_off)) >> 2;
    beats_full = min3(remaining, 32'(MAX_BURST), room);
  end

  // MAX_BURST <= 256 keeps the result within 9 bits.
  assign beats     = beats_full[8:0];
  assign unused_hi = beats_full[31:9];

endmodule

// File: rtl/dma_cmd_seq.sv
// rtl/dma_cmd_seq.sv - splits one register-configured DMA transfer into bounded bursts
module dma_cmd_seq
  import dma_cmd_seq_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BOUNDARY  = 4096,
  parameter int MAX_OUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cfg_ctrl,
  input  logic [31:0]          cfg_addr,
  input  logic [31:0]          cfg_len,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [CMD_LEN_W-1:0] cmd_len,
  input  logic                 cpl_valid,
  output logic [31:0]          status,
  output logic [31:0]          words_iss,
  output logic                 done_irq
);

  localparam int OFF_W = $clog2(BOUNDARY);

  state_t            state, state_n;
  logic              go_armed, go_prev, go;
  logic              abort;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       remaining, remaining_after;
  logic [7:0]        outstanding, out_n;
  logic [15:0]       bursts;
  logic              done_f, aborted_f, err_len_f, err_align_f, err_cpl_f;
  logic              hs, cpl_ok;
  logic [8:0]        beats, iss_beats;
  logic              bad_len, bad_align;
  logic [29:0]       unused_ctrl;

  assign unused_ctrl = cfg_ctrl[31:2];
  assign abort       = cfg_ctrl[1];
  assign go          = go_armed & ~go_prev & cfg_ctrl[0];
  assign bad_len     = (cfg_len == 32'd0);
  assign bad_align   = (cfg_addr[1:0] != 2'b00);

  assign hs              = (state == ST_ISSUE) && cmd_ready;
  assign cpl_ok          = cpl_valid && (outstanding != 8'd0);
  assign iss_beats       = {1'b0, cmd_len} + 9'd1;
  assign remaining_after = remaining - 32'(iss_beats);

  dma_burst_calc #(
    .MAX_BURST(MAX_BURST),
    .BOUNDARY (BOUNDARY)
  ) u_calc (
    .addr_off (addr[OFF_W-1:0]),
    .remaining(remaining),
    .beats    (beats)
  );

  // Outstanding count; a completion and a handshake in the same cycle cancel out.
  always_comb begin
    out_n = outstanding;
    case ({hs, cpl_ok})
      2'b10:   out_n = outstanding + 8'd1;
      2'b01:   out_n = outstanding - 8'd1;
      default: out_n = outstanding;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (go) state_n = (bad_len || bad_align) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        state_n = abort ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (hs) begin
          if (remaining_after == 32'd0)       state_n = ST_DRAIN;
          else if (out_n == 8'(MAX_OUT))      state_n = ST_WAIT;
          else                                state_n = ST_CALC;
        end
      end
      ST_WAIT: begin
        if (abort)                            state_n = ST_DRAIN;
        else if (outstanding < 8'(MAX_OUT))   state_n = ST_CALC;
      end
      ST_DRAIN: begin
        if (outstanding == 8'd0) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Go edge detect: arming needs a sampled 0 so a go held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_armed <= 1'b0;
      go_prev  <= 1'b0;
    end else begin
      go_prev <= cfg_ctrl[0];
      if (!cfg_ctrl[0]) go_armed <= 1'b1;
    end
  end

  // Transfer datapath, counters and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      remaining   <= '0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      words_iss   <= '0;
      outstanding <= '0;
      bursts      <= '0;
      done_f      <= 1'b0;
      aborted_f   <= 1'b0;
      err_len_f   <= 1'b0;
      err_align_f <= 1'b0;
      err_cpl_f   <= 1'b0;
    end else begin
      outstanding <= out_n;
      case (state)
        ST_IDLE: begin
          if (go) begin
            addr        <= ADDR_W'(cfg_addr);
            remaining   <= cfg_len;
            words_iss   <= '0;
            done_f      <= 1'b0;
            aborted_f   <= 1'b0;
            err_cpl_f   <= 1'b0;
            err_len_f   <= bad_len;
            err_align_f <= !bad_len && bad_align;
          end
        end
        ST_CALC: begin
          if (abort) begin
            aborted_f <= 1'b1;
          end else begin
            cmd_addr <= addr;
            cmd_len  <= CMD_LEN_W'(beats - 9'd1);
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            addr      <= addr + ADDR_W'({iss_beats, 2'b00});
            remaining <= remaining_after;
            words_iss <= words_iss + 32'(iss_beats);
            bursts    <= bursts + 16'd1;
          end
        end
        ST_WAIT: begin
          if (abort) aborted_f <= 1'b1;
        end
        ST_DONE: done_f <= 1'b1;
        default: ;
      endcase
      // A stray completion wins over the clear performed by a simultaneous go.
      if (cpl_valid && (outstanding == 8'd0)) err_cpl_f <= 1'b1;
    end
  end

  assign cmd_valid = (state == ST_ISSUE);
  assign done_irq  = (state == ST_DONE);

  always_comb begin
    status                     = '0;
    status[STAT_BUSY]          = (state != ST_IDLE);
    status[STAT_DONE]          = done_f;
    status[STAT_ABORTED]       = aborted_f;
    status[STAT_ERR_LEN]       = err_len_f;
    status[STAT_ERR_ALIGN]     = err_align_f;
    status[STAT_ERR_CPL]       = err_cpl_f;
    status[STAT_OUT_LSB +: 8]  = outstanding;
    status[STAT_BURST_LSB +: 16] = bursts;
  end

endmodule

// File: tb/tb_dma_cmd_seq.sv
// tb/tb_dma_cmd_seq.sv - directed self-checking bench for dma_cmd_seq
module tb_dma_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_ctrl = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_len  = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cpl_valid;
  logic [31:0] status;
  logic [31:0] words_iss;
  logic        done_irq;

  logic        auto_cpl = 1'b0;
  logic        man_cpl  = 1'b0;
  logic [2:0]  hs_pipe  = '0;
  int          hs_cnt   = 0;
  int          irq_cnt  = 0;
  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cpl_valid = (auto_cpl & hs_pipe[2]) | man_cpl;

  dma_cmd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_ctrl (cfg_ctrl),
    .cfg_addr (cfg_addr),
    .cfg_len  (cfg_len),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cpl_valid(cpl_valid),
    .status   (status),
    .words_iss(words_iss),
    .done_irq (done_irq)
  );

  // Records every accepted command and irq; completions follow commands by three cycles.
  always @(posedge clk) begin
    hs_pipe <= {hs_pipe[1:0], (!rst && cmd_valid && cmd_ready)};
    if (!rst && cmd_valid && cmd_ready) begin
      q_addr.push_back(cmd_addr);
      q_len.push_back(cmd_len);
      hs_cnt <= hs_cnt + 1;
    end
    if (!rst && done_irq) irq_cnt <= irq_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    cfg_ctrl  = '0;
    cmd_ready = 1'b0;
    auto_cpl  = 1'b0;
    man_cpl   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    cfg_addr = a;
    cfg_len  = l;
    cfg_ctrl = 32'h1;
    @(negedge clk);
    cfg_ctrl = 32'h0;
  endtask

  task automatic wait_irq(input int base, input string name);
    int n;
    n = 0;
    while (irq_cnt <= base && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq_cnt <= base) begin
      errors++;
      $display("FAIL %s_irq_timeout: got no done_irq within %0d cycles, required one", name, n);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: cmd_valid=%b, required 1", name, cmd_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (status !== 32'h0 || cmd_valid !== 1'b0 || words_iss !== 32'h0 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: status=%h valid=%b words=%h irq=%b, required 0", status, cmd_valid, words_iss, done_irq);
    end
    checks++;
    if (cmd_addr !== 32'h0 || cmd_len !== 8'h0) begin
      errors++;
      $display("FAIL reset_cmd_fields: addr=%h len=%h, required 0", cmd_addr, cmd_len);
    end
  endtask

  task automatic test_basic();
    int hb, ib;
    logic [31:0] ea[3];
    logic [7:0]  el[3];
    ea[0] = 32'h1000; ea[1] = 32'h1040; ea[2] = 32'h1080;
    el[0] = 8'd15;    el[1] = 8'd15;    el[2] = 8'd7;
    apply_reset();
    cmd_ready = 1'b1;
    auto_cpl  = 1'b1;
    hb = hs_cnt; ib = irq_cnt;
    start_xfer(32'h1000, 32'd40);
    wait_irq(ib, "basic");
    repeat (5) @(negedge clk);
    checks++;
    if (hs_cnt - hb !== 3) begin
      errors++;
      $display("FAIL basic_cmd_count: got %0d, required 3", hs_cnt - hb);
    end
    for (int i = 0; i < 3; i++) begin
      if (hb + i < q_addr.size()) begin
        checks++;
        if (q_addr[hb+i] !== ea[i] || q_len[hb+i] !== el[i]) begin
          errors++;
          $display("FAIL basic_cmd%0d: got (%h,%0d), required (%h,%0d)", i, q_addr[hb+i], q_len[hb+i], ea[i], el[i]);
        end
      end
    end
    checks++;
    if (irq_cnt - ib !== 1) begin
      errors++;
      $display("FAIL basic_irq_count: got %0d, required 1", irq_cnt - ib);
    end
    checks++;
    if (status !== 32'h0003_0002) begin
      errors++;
      $display("FAIL basic_status: got %h, required 00030002", status);
    end
    checks++;
    if (words_iss !== 32'd40) begin
      errors++;
      $display("FAIL basic_words_iss: got %0d, required 40", words_iss);
    end
  endtask

  task automatic test_boundary();
    int hb, ib;
    apply_reset();
    cmd_ready = 1'b1;
    auto_cpl  = 1'b1;
    hb = hs_cnt; ib = irq_cnt;
    start_xfer(32'h1FF8, 32'd8);
    wait_irq(ib, "boundary");
    repeat (3) @(negedge clk);
    checks++;
    if (hs_cnt - hb !== 2) begin
      errors++;
      $display("FAIL boundary_cmd_count: got %0d, required 2", hs_cnt - hb);
    end else begin
      checks++;
      if (q_addr[hb] !== 32'h1FF8 || q_len[hb] !== 8'd1) begin
        errors++;
        $display("FAIL boundary_cmd0: got (%h,%0d), required (00001ff8,1)", q_addr[hb], q_len[hb]);
      end
      checks++;
      if (q_addr[hb+1] !== 32'h2000 || q_len[hb+1] !== 8'd5) begin
        errors++;
        $display("FAIL boundary_cmd1: got (%h,%0d), required (00002000,5)", q_addr[hb+1], q_len[hb+1]);
      end
    end
    checks++;
    if (words_iss !== 32'd8) begin
      errors++;
      $display("FAIL boundary_words_iss: got %0d, required 8", words_iss);
    end
  endtask

  task automatic test_max_out();
    int hb;
    apply_reset();
    cmd_ready = 1'b1;
    hb = hs_cnt;
    start_xfer(32'h0, 32'd128);
    repeat (30) @(negedge clk);
    checks++;
    if (hs_cnt - hb !== 4 || cmd_valid !== 1'b0 || status[15:8] !== 8'd4) begin
      errors++;
      $display("FAIL maxout_stall: hs=%0d valid=%b out=%0d, required 4/0/4", hs_cnt - hb, cmd_valid, status[15:8]);
    end
    cmd_ready = 1'b0;
    man_cpl   = 1'b1;
    @(negedge clk);
    man_cpl = 1'b0;
    checks++;
    if (status[15:8] !== 8'd3) begin
      errors++;
      $display("FAIL maxout_after_cpl: outstanding=%0d, required 3", status[15:8]);
    end
    wait_valid("maxout");
    checks++;
    if (cmd_addr !== 32'h100 || cmd_len !== 8'd15) begin
      errors++;
      $display("FAIL maxout_cmd5_fields: got (%h,%0d), required (00000100,15)", cmd_addr, cmd_len);
    end
    cmd_ready = 1'b1;
    man_cpl   = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    man_cpl   = 1'b0;
    checks++;
    if (hs_cnt - hb !== 5 || status[15:8] !== 8'd3 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL maxout_hs_with_cpl: hs=%0d out=%0d valid=%b, required 5/3/0", hs_cnt - hb, status[15:8], cmd_valid);
    end
  endtask

  task automatic test_abort();
    int hb, ib, n;
    apply_reset();
    cmd_ready = 1'b1;
    hb = hs_cnt; ib = irq_cnt;
    start_xfer(32'h0, 32'd128);
    n = 0;
    while (hs_cnt - hb < 2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    cfg_ctrl = 32'h2;
    repeat (10) @(negedge clk);
    checks++;
    if (hs_cnt - hb !== 2 || cmd_valid !== 1'b0 || status[2] !== 1'b1 || irq_cnt != ib) begin
      errors++;
      $display("FAIL abort_stop: hs=%0d valid=%b aborted=%b irqs=%0d, required 2/0/1/0", hs_cnt - hb, cmd_valid, status[2], irq_cnt - ib);
    end
    cfg_ctrl = 32'h0;
    man_cpl  = 1'b1;
    @(negedge clk);
    man_cpl = 1'b0;
    @(negedge clk);
    man_cpl = 1'b1;
    @(negedge clk);
    man_cpl = 1'b0;
    wait_irq(ib, "abort");
    repeat (2) @(negedge clk);
    checks++;
    if (status[2:1] !== 2'b11 || status[0] !== 1'b0 || words_iss !== 32'd32) begin
      errors++;
      $display("FAIL abort_final: status=%h words=%0d, required status[2:0]=110 words=32", status, words_iss);
    end
  endtask

  task automatic test_errors();
    int hb, ib;
    apply_reset();
    cmd_ready = 1'b1;
    hb = hs_cnt; ib = irq_cnt;
    start_xfer(32'h1000, 32'd0);
    wait_irq(ib, "len0");
    @(negedge clk);
    checks++;
    if (status[4:1] !== 4'b0101 || hs_cnt != hb) begin
      errors++;
      $display("FAIL err_len: status=%h hs=%0d, required status[4:1]=0101 hs=0", status, hs_cnt - hb);
    end
    ib = irq_cnt;
    start_xfer(32'h1002, 32'd4);
    wait_irq(ib, "align");
    @(negedge clk);
    checks++;
    if (status[4:1] !== 4'b1001 || hs_cnt != hb) begin
      errors++;
      $display("FAIL err_align: status=%h hs=%0d, required status[4:1]=1001 hs=0", status, hs_cnt - hb);
    end
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    start_xfer(32'h40, 32'd4);
    wait_valid("midrst");
    @(negedge clk);
    cfg_ctrl = 32'h1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || status !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b status=%h, required 0/0", cmd_valid, status);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || status[0] !== 1'b0) begin
      errors++;
      $display("FAIL go_held_through_reset: valid=%b busy=%b, required 0/0", cmd_valid, status[0]);
    end
    cfg_ctrl = 32'h0;
    @(negedge clk);
    cfg_ctrl = 32'h1;
    @(negedge clk);
    cfg_ctrl = 32'h0;
    wait_valid("rearm");
  endtask

  task automatic test_stray_cpl();
    apply_reset();
    man_cpl = 1'b1;
    @(negedge clk);
    man_cpl = 1'b0;
    @(negedge clk);
    checks++;
    if (status !== 32'h0000_0020) begin
      errors++;
      $display("FAIL stray_cpl: status=%h, required 00000020", status);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_max_out();
    test_abort();
    test_errors();
    test_reset_mid_issue();
    test_stray_cpl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
